pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Dead-time insertion stage placed directly downstream of the triangle-compare PWM generator. It converts that generator's single registered `pwm` bit into a complementary high-side/low-side gate-drive pair for one half-bridge leg. Between any change of drive it inserts a programmable interval in which both outputs are off. It also provides a latched fault shutdown and a switching-cycle counter.

## Interface
Parameters:
- `DT_W`, default 8: width of the dead-time value.
- `CNT_W`, default 16: width of the switching-cycle counter.

Ports:
- `clk`  in  1: system clock, shared with the PWM generator.
- `rst`  in  1: reset, asynchronous and active-high.
- `pwm_in`  in  1: PWM request, synchronous to `clk`. 1 requests high side; 0 requests low side.
- `dt_cycles`  in  DT_W: dead time in clk cycles. Value 0 is treated as 1.
- `fault_in`  in  1: level-sensitive fault request.
- `fault_clr`  in  1: single-cycle request to leave the fault state.
- `hs`  out  1: high-side gate drive, registered.
- `ls`  out  1: low-side gate drive, registered.
- `fault_latched`  out  1: 1 while in the FAULT state, registered.
- `sw_cnt`  out  CNT_W: number of HS_ON entries; wraps.

## Operation
States: DT_HS, HS_ON, DT_LS, LS_ON, FAULT.
- Output decode: `hs`=1 only in HS_ON; `ls`=1 only in LS_ON; `fault_latched`=1 only in FAULT.
- `hs` and `ls` are never both 1 in any cycle. This is a hard invariant and is checked by assertion.
- Reset state is DT_LS, with the counter loaded to the reset value of `dt_cycles` (0 is read as 1).
- Reset values: `hs`=0, `ls`=0, `fault_latched`=0, `sw_cnt`=0.
- Dead counter `cnt` (DT_W bits) is loaded with max(`dt_cycles`,1) on every entry to DT_HS or DT_LS. Changes to `dt_cycles` during a dead interval are ignored.

Transitions, evaluated at each clk edge. FAULT has priority over all others.
- Any state with `fault_in`=1 → FAULT.
- HS_ON with `pwm_in`=0 → DT_LS.
- LS_ON with `pwm_in`=1 → DT_HS.
- DT_HS:
  - `pwm_in`=0 → LS_ON (abort; the opposite side was off for the whole dead interval, so no new dead time is needed).
  - Else, `cnt`==1 → HS_ON and `sw_cnt` += 1.
  - Else `cnt` -= 1.
- DT_LS: mirror of DT_HS.
  - `pwm_in`=1 → HS_ON, and `sw_cnt` += 1.
  - Else, `cnt`==1 → LS_ON.
  - Else `cnt` -= 1.
- FAULT with `fault_clr`=1 and `fault_in`=0 → DT_LS if `pwm_in`=0, or DT_HS if `pwm_in`=1, with `cnt` loaded.
  - `fault_clr` while `fault_in`=1 is ignored.
  - FAULT never exits without `fault_clr`.
- `sw_cnt` wraps from 2^CNT_W−1 to 0 and has no saturation. It holds its value through FAULT.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously).

## Timing
- `pwm_in` change seen at edge k: the active side drops at edge k, so it is low in cycle k+1.
- The opposite side rises at edge k+D, where D = max(`dt_cycles`,1). Both outputs are therefore low for exactly D cycles.
- Minimum both-off interval is 1 cycle, including when `dt_cycles`=0.
- `pwm_in` pulse shorter than D cycles: the opposite side never turns on, and the original side resumes one edge after `pwm_in` returns.
- Fault latency: `fault_in` sampled high at edge k gives `hs`=`ls`=0 and `fault_latched`=1 from edge k.
- Fault exit: `fault_clr` at edge k enters the dead state at k. The first drive is at k+D.
- No combinational path from any input to any output.

## Test plan
- Reset release, `pwm_in`=0, `dt_cycles`=4 → both outputs 0 for 4 cycles, then `ls`=1; `sw_cnt`=0.
- `pwm_in` 0→1 at edge k, `dt_cycles`=3 → `ls`=0 at k, `hs`=1 at k+3; `sw_cnt` increments by 1 at k+3.
- `dt_cycles`=0 with toggling `pwm_in` → exactly 1 both-off cycle per transition; overlap assertion never fires.
- `dt_cycles`=5 with a 2-cycle `pwm_in` high glitch from LS_ON → `hs` stays 0, `ls` returns to 1 after the glitch, `sw_cnt` unchanged.
- `fault_in` pulse during HS_ON → `hs`=0 and `fault_latched`=1 at the next edge.
  - `fault_clr` while `fault_in`=1 → ignored.
  - `fault_clr` after `fault_in` falls → drive resumes D cycles later.
- Drive 65,537 HS_ON entries with `CNT_W`=16 → `sw_cnt`=1. Assert `rst` mid-dead-interval → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Dead-time insertion for one half-bridge leg: turns a single pwm request into a
// complementary hs/ls pair with a programmable both-off gap, fault latch and entry counter.
//
// state   | meaning
// DT_HS   | both off, waiting out dead time before high side
// HS_ON   | high side driven
// DT_LS   | both off, waiting out dead time before low side
// LS_ON   | low side driven
// FAULT   | both off, latched until fault_clr with fault_in low
module pwm_deadtime #(
  parameter int DT_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic [DT_W-1:0]  dt_cycles,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             hs,
  output logic             ls,
  output logic             fault_latched,
  output logic [CNT_W-1:0] sw_cnt
);

  typedef enum logic [2:0] {
    S_DT_HS = 3'd0,
    S_HS_ON = 3'd1,
    S_DT_LS = 3'd2,
    S_LS_ON = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [DT_W-1:0] cnt, cnt_nxt;
  logic [DT_W-1:0] dt_eff;
  logic [DT_W-1:0] cnt_cur;
  logic            sw_inc;

  assign dt_eff = (dt_cycles == '0) ? DT_W'(1) : dt_cycles;

  // cnt resets to 0 so the reset load needs no data-dependent async value;
  // a zero count in a dead state means "first dead cycle after reset".
  assign cnt_cur = (cnt == '0) ? dt_eff : cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sw_inc    = 1'b0;
    if (fault_in) begin
      state_nxt = S_FAULT;
    end else begin
      case (state)
        S_HS_ON: begin
          if (!pwm_in) begin
            state_nxt = S_DT_LS;
            cnt_nxt   = dt_eff;
          end
        end
        S_LS_ON: begin
          if (pwm_in) begin
            state_nxt = S_DT_HS;
            cnt_nxt   = dt_eff;
          end
        end
        S_DT_HS: begin
          if (!pwm_in) begin
            state_nxt = S_LS_ON;
          end else if (cnt_cur == DT_W'(1)) begin
            state_nxt = S_HS_ON;
            sw_inc    = 1'b1;
          end else begin
            cnt_nxt = cnt_cur - DT_W'(1);
          end
        end
        S_DT_LS: begin
          // the high side was off for the whole interval, so an abort goes straight on
          if (pwm_in) begin
            state_nxt = S_HS_ON;
            sw_inc    = 1'b1;
          end else if (cnt_cur == DT_W'(1)) begin
            state_nxt = S_LS_ON;
          end else begin
            cnt_nxt = cnt_cur - DT_W'(1);
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            state_nxt = pwm_in ? S_DT_HS : S_DT_LS;
            cnt_nxt   = dt_eff;
          end
        end
        default: begin
          state_nxt = S_DT_LS;
          cnt_nxt   = dt_eff;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_DT_LS;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // outputs decoded from the next state so each is a plain flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs            <= 1'b0;
      ls            <= 1'b0;
      fault_latched <= 1'b0;
      sw_cnt        <= '0;
    end else begin
      hs            <= (state_nxt == S_HS_ON);
      ls            <= (state_nxt == S_LS_ON);
      fault_latched <= (state_nxt == S_FAULT);
      if (sw_inc) sw_cnt <= sw_cnt + CNT_W'(1);
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(hs && ls));

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and randomized checks of pwm_deadtime against a side/dead-time model;
// a second 4-bit-counter instance exercises sw_cnt wrap.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] dt_cycles;
  logic       fault_in;
  logic       fault_clr;
  logic       hs, ls, fault_latched;
  logic [15:0] sw_cnt;
  logic       hs_s, ls_s, fl_s;
  logic [3:0] sw_cnt_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(.DT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .dt_cycles(dt_cycles),
    .fault_in(fault_in), .fault_clr(fault_clr),
    .hs(hs), .ls(ls), .fault_latched(fault_latched), .sw_cnt(sw_cnt)
  );

  pwm_deadtime #(.DT_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .dt_cycles(dt_cycles),
    .fault_in(fault_in), .fault_clr(fault_clr),
    .hs(hs_s), .ls(ls_s), .fault_latched(fl_s), .sw_cnt(sw_cnt_s)
  );

  // model: which side is driven (0 none, 1 high, 2 low), the side a dead
  // interval is heading for, how many both-off cycles remain, fault flag
  int          m_side;
  int          m_target;
  int          m_left;
  bit          m_fault;
  int unsigned m_entries;

  function automatic int dmax(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_side    = 0;
    m_target  = 2;
    m_left    = dmax(dt_cycles);
    m_fault   = 1'b0;
    m_entries = 0;
  endtask

  task automatic turn_on(input int side);
    m_side = side;
    if (side == 1) m_entries++;
  endtask

  task automatic model_edge();
    int want;
    want = pwm_in ? 1 : 2;
    if (fault_in) begin
      m_fault = 1'b1;
      m_side  = 0;
    end else if (m_fault) begin
      if (fault_clr) begin
        m_fault  = 1'b0;
        m_target = want;
        m_left   = dmax(dt_cycles);
      end
    end else if (m_side != 0) begin
      if (want != m_side) begin
        m_side   = 0;
        m_target = want;
        m_left   = dmax(dt_cycles);
      end
    end else begin
      if (want != m_target) turn_on(want);
      else if (m_left == 1) turn_on(m_target);
      else m_left--;
    end
  endtask

  task automatic check_all();
    chk("hs", 32'(hs), 32'(m_side == 1));
    chk("ls", 32'(ls), 32'(m_side == 2));
    chk("fault_latched", 32'(fault_latched), 32'(m_fault));
    chk("sw_cnt", 32'(sw_cnt), m_entries & 32'hffff);
    chk("sw_cnt_wrap4", 32'(sw_cnt_s), m_entries & 32'hf);
    chk("no_overlap", 32'(hs & ls), 32'd0);
  endtask

  task automatic cyc(input logic p, input logic [7:0] d, input logic f, input logic c);
    pwm_in = p; dt_cycles = d; fault_in = f; fault_clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int unsigned snap;
    int hold, frem;
    logic p, f, c;
    logic [7:0] d;

    rst = 1'b1; pwm_in = 1'b0; dt_cycles = 8'd4; fault_in = 1'b0; fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hs", 32'(hs), 32'd0);
    chk("rst_ls", 32'(ls), 32'd0);
    chk("rst_fl", 32'(fault_latched), 32'd0);
    chk("rst_sw", 32'(sw_cnt), 32'd0);
    rst = 1'b0;
    model_reset();

    // reset release, dt=4: three more off cycles, ls on at the fourth edge
    repeat (3) begin
      cyc(1'b0, 8'd4, 1'b0, 1'b0);
      chk("boot_ls_off", 32'(ls), 32'd0);
    end
    cyc(1'b0, 8'd4, 1'b0, 1'b0);
    chk("boot_ls_on", 32'(ls), 32'd1);
    chk("boot_sw", 32'(sw_cnt), 32'd0);

    // 0->1 with dt=3
    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    chk("dt3_ls_drop", 32'(ls), 32'd0);
    repeat (2) begin
      cyc(1'b1, 8'd3, 1'b0, 1'b0);
      chk("dt3_hs_wait", 32'(hs), 32'd0);
    end
    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    chk("dt3_hs_on", 32'(hs), 32'd1);
    chk("dt3_sw", 32'(sw_cnt), 32'd1);

    // dt=0 toggling: exactly one both-off cycle per change
    for (int i = 0; i < 6; i++) begin
      cyc(i[0] ? 1'b1 : 1'b0, 8'd0, 1'b0, 1'b0);
      chk("dt0_gap", 32'(hs | ls), 32'd0);
      repeat (2) cyc(i[0] ? 1'b1 : 1'b0, 8'd0, 1'b0, 1'b0);
      chk("dt0_on", 32'(hs | ls), 32'd1);
    end

    // short high glitch from LS_ON with dt=5
    repeat (8) cyc(1'b0, 8'd5, 1'b0, 1'b0);
    snap = m_entries;
    repeat (2) begin
      cyc(1'b1, 8'd5, 1'b0, 1'b0);
      chk("glitch_hs", 32'(hs), 32'd0);
    end
    cyc(1'b0, 8'd5, 1'b0, 1'b0);
    chk("glitch_ls_back", 32'(ls), 32'd1);
    chk("glitch_sw", 32'(sw_cnt), snap & 32'hffff);

    // fault during HS_ON, ignored clear, then real clear with dt=2
    repeat (6) cyc(1'b1, 8'd2, 1'b0, 1'b0);
    cyc(1'b1, 8'd2, 1'b1, 1'b0);
    chk("fault_hs", 32'(hs), 32'd0);
    chk("fault_fl", 32'(fault_latched), 32'd1);
    cyc(1'b1, 8'd2, 1'b1, 1'b1);
    chk("fault_clr_ignored", 32'(fault_latched), 32'd1);
    repeat (2) begin
      cyc(1'b1, 8'd2, 1'b0, 1'b0);
      chk("fault_hold", 32'(fault_latched), 32'd1);
    end
    cyc(1'b1, 8'd2, 1'b0, 1'b1);
    chk("fault_exit", 32'(fault_latched), 32'd0);
    chk("fault_exit_hs", 32'(hs), 32'd0);
    cyc(1'b1, 8'd2, 1'b0, 1'b0);
    chk("fault_exit_wait", 32'(hs), 32'd0);
    cyc(1'b1, 8'd2, 1'b0, 1'b0);
    chk("fault_exit_hs_on", 32'(hs), 32'd1);

    // 17 fast high-side entries wrap the 4-bit counter
    snap = m_entries;
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 8'd3, 1'b0, 1'b0);
      cyc(1'b1, 8'd3, 1'b0, 1'b0);
    end
    chk("wrap4", 32'(sw_cnt_s), (snap + 17) & 32'hf);

    // randomized run
    hold = 0; frem = 0; p = 1'b0; d = 8'd2;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        p = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) d = 8'($urandom_range(0, 6));
      if (frem == 0 && $urandom_range(0, 99) == 0) frem = $urandom_range(1, 4);
      f = (frem > 0);
      if (frem > 0) frem--;
      c = ($urandom_range(0, 7) == 0);
      cyc(p, d, f, c);
    end
    repeat (4) cyc(1'b0, 8'd2, 1'b0, 1'b1);

    // async reset in the middle of a dead interval
    repeat (12) cyc(1'b1, 8'd6, 1'b0, 1'b0);
    cyc(1'b0, 8'd6, 1'b0, 1'b0);
    cyc(1'b0, 8'd6, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_hs", 32'(hs), 32'd0);
    chk("arst_ls", 32'(ls), 32'd0);
    chk("arst_fl", 32'(fault_latched), 32'd0);
    chk("arst_sw", 32'(sw_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) cyc(1'b0, 8'd6, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
